// File: rtl/multi_clk_en_gen.sv
// ---------------------------------------------------------------------------
// multi_clk_en_gen
//
// Purpose:
//   Multi-channel clock-enable generator. A shared prescaler divides Clk down
//   to a base Tick enable. NCH channels each divide Tick by a divisor that can
//   be loaded at runtime. Every channel produces a one-cycle enable pulse and
//   a toggle output. All consumers stay on Clk and no clock is gated.
//
// Optional feature (compile-time macro PHASE_ALIGN_EN):
//   When the macro is defined, any accepted divisor load also clears the
//   prescaler and every channel count on the same edge, and Tick is
//   suppressed on that edge. All channels then share a common phase. When it
//   is undefined, only the addressed channel count is cleared.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   asynchronous, active-high reset
//   Ch_en      in   [NCH]   per-channel run enable
//   Div_load   in   single-cycle strobe that loads Div_val into channel Div_sel
//   Div_sel    in   [SEL_W] target channel of the load
//   Div_val    in   [DIV_W] new divisor; 0 stops the channel
//   Tick       out  base enable, high for one cycle every PRE cycles
//   Ch_pulse   out  [NCH]   per-channel enable pulse, one cycle wide
//   Ch_toggle  out  [NCH]   per-channel square wave, inverts on each pulse
//
// Load handshake:
//   Div_load has no ready. The load takes effect on the rising edge where
//   Div_load is high, but only if Div_sel addresses an existing channel.
//   A load with Div_sel >= NCH is dropped and changes no state.
// ---------------------------------------------------------------------------
module multi_clk_en_gen #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int NCH      = 4,
   parameter int DIV_W    = 16,
   parameter int DIV_INIT = 1,
   localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [NCH-1:0]   Ch_en,
   input  logic             Div_load,
   input  logic [SEL_W-1:0] Div_sel,
   input  logic [DIV_W-1:0] Div_val,
   output logic             Tick,
   output logic [NCH-1:0]   Ch_pulse,
   output logic [NCH-1:0]   Ch_toggle
);

   localparam int PRE   = CLK_FREQ / TICK_HZ;
   localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

`ifdef PHASE_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic [PRE_W-1:0] pre_cnt;
   logic             tick_q;
   logic [DIV_W-1:0] div_q [NCH];
   logic [DIV_W-1:0] cnt_q [NCH];
   logic [NCH-1:0]   pulse_q;
   logic [NCH-1:0]   toggle_q;

   logic [SEL_W:0]   sel_ext;
   logic             load_acc;
   logic             pre_wrap;
   logic             align_clr;

   // One extra bit lets Div_sel be compared against NCH even when NCH is a
   // power of two.
   assign sel_ext   = {1'b0, Div_sel};
   assign load_acc  = Div_load && (sel_ext < (SEL_W+1)'(NCH));
   assign pre_wrap  = (pre_cnt == PRE_W'(PRE - 1));
   assign align_clr = ALIGN && load_acc;

   // Prescaler: counts 0..PRE-1. Tick is registered on the wrap edge, so it
   // is high in the cycle after that edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pre_cnt <= '0;
         tick_q  <= 1'b0;
      end else if (align_clr) begin
         pre_cnt <= '0;
         tick_q  <= 1'b0;
      end else if (pre_wrap) begin
         pre_cnt <= '0;
         tick_q  <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
         tick_q  <= 1'b0;
      end
   end

   // Channel dividers. The priority order matters:
   //   1. A load to this channel wins over a coinciding terminal count, so the
   //      pulse is dropped and the toggle holds.
   //   2. With phase alignment, a load to any channel clears this count.
   //   3. A disabled or stopped (div = 0) channel keeps its count at 0. The
   //      first pulse after re-enable therefore comes div Ticks later.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NCH; i++) begin
            div_q[i] <= DIV_W'(DIV_INIT);
            cnt_q[i] <= '0;
         end
         pulse_q  <= '0;
         toggle_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load_acc && (sel_ext == (SEL_W+1)'(i))) begin
               div_q[i]   <= Div_val;
               cnt_q[i]   <= '0;
               pulse_q[i] <= 1'b0;
            end else if (align_clr) begin
               cnt_q[i]   <= '0;
               pulse_q[i] <= 1'b0;
            end else if (!Ch_en[i] || (div_q[i] == '0)) begin
               cnt_q[i]   <= '0;
               pulse_q[i] <= 1'b0;
            end else if (tick_q && (cnt_q[i] == div_q[i] - DIV_W'(1))) begin
               cnt_q[i]    <= '0;
               pulse_q[i]  <= 1'b1;
               toggle_q[i] <= ~toggle_q[i];
            end else if (tick_q) begin
               cnt_q[i]   <= cnt_q[i] + DIV_W'(1);
               pulse_q[i] <= 1'b0;
            end else begin
               pulse_q[i] <= 1'b0;
            end
         end
      end
   end

   assign Tick      = tick_q;
   assign Ch_pulse  = pulse_q;
   assign Ch_toggle = toggle_q;

endmodule

// File: tb/tb_multi_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_clk_en_gen
//
// Testbench for multi_clk_en_gen with PRE = 10, NCH = 2 and DIV_W = 4. A
// second instance with NCH = 3 covers a load to a channel that does not exist.
// The expected Tick and pulse events are computed by hand and queued as
// {cycle, toggle-after-pulse}. A negedge monitor pops an entry from the queue
// every time the DUT raises one of these outputs. Cycle n is the n-th rising
// edge after Reset is released.
// ---------------------------------------------------------------------------
module tb_multi_clk_en_gen;

   localparam int NCH   = 2;
   localparam int DIV_W = 4;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic [NCH-1:0]   Ch_en;
   logic             Div_load;
   logic [0:0]       Div_sel;
   logic [DIV_W-1:0] Div_val;
   logic             Tick;
   logic [NCH-1:0]   Ch_pulse;
   logic [NCH-1:0]   Ch_toggle;

   logic [2:0]       en3;
   logic             load3;
   logic [1:0]       sel3;
   logic [DIV_W-1:0] val3;
   logic             tick3;
   logic [2:0]       pulse3;
   logic [2:0]       toggle3;

   multi_clk_en_gen #(
      .CLK_FREQ(10), .TICK_HZ(1), .NCH(NCH), .DIV_W(DIV_W), .DIV_INIT(1)
   ) u_dut (
      .Clk(Clk), .Reset(Reset), .Ch_en(Ch_en), .Div_load(Div_load),
      .Div_sel(Div_sel), .Div_val(Div_val), .Tick(Tick),
      .Ch_pulse(Ch_pulse), .Ch_toggle(Ch_toggle)
   );

   multi_clk_en_gen #(
      .CLK_FREQ(10), .TICK_HZ(1), .NCH(3), .DIV_W(DIV_W), .DIV_INIT(1)
   ) u_dut3 (
      .Clk(Clk), .Reset(Reset), .Ch_en(en3), .Div_load(load3),
      .Div_sel(sel3), .Div_val(val3), .Tick(tick3),
      .Ch_pulse(pulse3), .Ch_toggle(toggle3)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 Clk = ~Clk;

   int cyc;
   always @(posedge Clk or posedge Reset) begin
      if (Reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q0[$];   // Tick
   logic [15:0] exp_q1[$];   // Ch_pulse[0]
   logic [15:0] exp_q2[$];   // Ch_pulse[1]

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int s, input int c, input logic t);
      logic [15:0] v;
      logic [31:0] cw;
      cw = c;
      v  = {cw[14:0], t};
      case (s)
         0: exp_q0.push_back(v);
         1: exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endtask

   task automatic mon_one(input int s, input logic tog);
      logic [15:0] got;
      logic [15:0] exp;
      logic [31:0] cw;
      int sz;
      cw  = cyc;
      got = {cw[14:0], tog};
      case (s)
         0: sz = exp_q0.size();
         1: sz = exp_q1.size();
         default: sz = exp_q2.size();
      endcase
      n_vec++;
      if (sz == 0) begin
         n_err++;
         $display("FAIL stream%0d unexpected pulse at cyc %0d toggle %0b", s, cyc, tog);
      end else begin
         case (s)
            0: exp = exp_q0.pop_front();
            1: exp = exp_q1.pop_front();
            default: exp = exp_q2.pop_front();
         endcase
         if (got !== exp) begin
            n_err++;
            $display("FAIL stream%0d event: got cyc %0d toggle %0b, expected cyc %0d toggle %0b",
                     s, got[15:1], got[0], exp[15:1], exp[0]);
         end
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset) begin
         if (Tick)        mon_one(0, 1'b0);
         if (Ch_pulse[0]) mon_one(1, Ch_toggle[0]);
         if (Ch_pulse[1]) mon_one(2, Ch_toggle[1]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n) begin
         @(negedge Clk);
         guard++;
         if (guard > 2000) begin
            n_err++;
            $display("FAIL wait_cyc timeout waiting for cyc %0d (at %0d)", n, cyc);
            $fatal(1, "wait bound expired");
         end
      end
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      Div_load = 1'b0;
      load3    = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_tick",    32'(Tick),      0);
      check("rst_pulse",   32'(Ch_pulse),  0);
      check("rst_toggle",  32'(Ch_toggle), 0);
      check("rst_pulse3",  32'(pulse3),    0);
      check("rst_toggle3", 32'(toggle3),   0);
      Reset = 1'b0;
   endtask

   // The load is sampled on the rising edge numbered 'edge_n'.
   task automatic load(input logic [0:0] ch, input logic [DIV_W-1:0] val, input int edge_n);
      wait_cyc(edge_n - 1);
      Div_sel  = ch;
      Div_val  = val;
      Div_load = 1'b1;
      @(negedge Clk);
      Div_load = 1'b0;
   endtask

   task automatic end_scn(input string name);
      check({name, "_tick_left"}, 32'(exp_q0.size()), 0);
      check({name, "_p0_left"},   32'(exp_q1.size()), 0);
      check({name, "_p1_left"},   32'(exp_q2.size()), 0);
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Ch_en    = 2'b11;
      Div_load = 1'b0;
      Div_sel  = '0;
      Div_val  = '0;
      en3      = 3'b111;
      load3    = 1'b0;
      sel3     = '0;
      val3     = '0;

      // A: default divisor 1 on both channels.
      for (int k = 1; k <= 4; k++) begin
         push(0, 10*k, 1'b0);
         push(1, 10*k + 1, 1'(k % 2));
         push(2, 10*k + 1, 1'(k % 2));
      end
      do_reset();
      wait_cyc(46);
      end_scn("A");

      // B: ch0 loaded with 3 on edge 2; ch1 is not disturbed.
      for (int k = 1; k <= 9; k++) begin
         push(0, 10*k, 1'b0);
         push(2, 10*k + 1, 1'(k % 2));
      end
      push(1, 31, 1'b1);
      push(1, 61, 1'b0);
      push(1, 91, 1'b1);
      do_reset();
      load(1'b0, 4'd3, 2);
      wait_cyc(96);
      end_scn("B");

      // C: ch1 stopped with 0 on edge 15, restarted with 2 on edge 35.
      for (int k = 1; k <= 7; k++) begin
         push(0, 10*k, 1'b0);
         push(1, 10*k + 1, 1'(k % 2));
      end
      push(2, 11, 1'b1);
      push(2, 51, 1'b0);
      push(2, 71, 1'b1);
      do_reset();
      load(1'b1, 4'd0, 15);
      wait_cyc(34);
      check("C_tog1_frozen", 32'(Ch_toggle[1]), 1);
      load(1'b1, 4'd2, 35);
      wait_cyc(76);
      end_scn("C");

      // D: ch0 load collides with its fire on edge 21. A load to the missing
      // channel 3 of the NCH=3 instance is ignored. Ch_en[1] is low from
      // edge 25 to edge 34.
      for (int k = 1; k <= 7; k++) push(0, 10*k, 1'b0);
      push(1, 11, 1'b1);
      push(1, 31, 1'b0);
      push(1, 41, 1'b1);
      push(1, 51, 1'b0);
      push(1, 61, 1'b1);
      push(1, 71, 1'b0);
      push(2, 61, 1'b1);
      do_reset();
      load(1'b1, 4'd3, 2);
      wait_cyc(20);
      Div_sel  = 1'b0;
      Div_val  = 4'd1;
      Div_load = 1'b1;
      sel3     = 2'd3;
      val3     = 4'd5;
      load3    = 1'b1;
      @(negedge Clk);
      Div_load = 1'b0;
      load3    = 1'b0;
      check("D_sel3_pulse_c21", 32'(pulse3), 32'h7);
      wait_cyc(24);
      Ch_en = 2'b01;
      wait_cyc(31);
      check("D_sel3_pulse_c31", 32'(pulse3), 32'h7);
      wait_cyc(34);
      Ch_en = 2'b11;
      wait_cyc(76);
      end_scn("D");
      check("D_tog_pre_rst", 32'(Ch_toggle), 32'h2);

      // E: asynchronous reset between edges clears the outputs immediately.
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      check("E_async_tick",   32'(Tick),      0);
      check("E_async_pulse",  32'(Ch_pulse),  0);
      check("E_async_toggle", 32'(Ch_toggle), 0);
      check("E_async_tog3",   32'(toggle3),   0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
